// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: start, DATA_W data bits, optional parity, 1 or 2 stop bits.
// Latency: a Data_Valid accepted at edge N puts the start bit on the line from cycle N+1.
// Backpressure: none. busy is advisory, and a strobe the block cannot take is dropped and flagged on ovr_err.
module uart_tx_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              Data_Valid,
    input  logic [DATA_W-1:0] P_DATA,
    input  logic              PAR_EN,
    input  logic              PAR_TYP,
    input  logic              STOP2,
    input  logic              ser_done,
    output logic              ser_en,
    output logic [1:0]        mux_sel,
    output logic              par_bit,
    output logic              busy,
    output logic              ovr_err,
    output logic              frame_err
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] bit_cnt;
    logic             par_en_q;
    logic             stop2_q;
    logic             last_stop;
    logic             accept;
    logic             data_last;
    logic             data_exit;

    // The final stop cycle doubles as an accept slot so frames can run back-to-back.
    assign last_stop = (state == S_STOP2) || ((state == S_STOP1) && !stop2_q);
    assign accept    = Data_Valid && ((state == S_IDLE) || last_stop);
    assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
    assign data_exit = ser_done || data_last;

    always_comb begin
        state_nxt = state;
        mux_sel   = 2'b01;
        ser_en    = 1'b0;
        busy      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                if (accept) state_nxt = S_START;
            end
            S_START: begin
                mux_sel   = 2'b00;
                ser_en    = 1'b1;
                state_nxt = S_DATA;
            end
            S_DATA: begin
                mux_sel = 2'b10;
                ser_en  = ~ser_done;
                if (data_exit) state_nxt = par_en_q ? S_PARITY : S_STOP1;
            end
            S_PARITY: begin
                mux_sel   = 2'b11;
                state_nxt = S_STOP1;
            end
            S_STOP1: begin
                if (stop2_q)     state_nxt = S_STOP2;
                else if (accept) state_nxt = S_START;
                else             state_nxt = S_IDLE;
            end
            S_STOP2: begin
                state_nxt = accept ? S_START : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            par_en_q  <= 1'b0;
            stop2_q   <= 1'b0;
            par_bit   <= 1'b0;
            ovr_err   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_START)     bit_cnt <= '0;
            else if (state == S_DATA) bit_cnt <= bit_cnt + 1'b1;
            if (accept) begin
                par_en_q <= PAR_EN;
                stop2_q  <= STOP2;
                par_bit  <= (^P_DATA) ^ PAR_TYP;
            end
            ovr_err   <= Data_Valid && !accept && (state != S_IDLE);
            // Fault when the serializer's done pulse and the counter disagree on the last bit.
            frame_err <= (state == S_DATA) && data_exit && (ser_done != data_last);
        end
    end

endmodule
